// File: rtl/pipeline_debug_ctrl.sv
// rtl/pipeline_debug_ctrl.sv - debug controller: program load, run/step control and state dump
module pipeline_debug_ctrl #(
    parameter int INST_SZ    = 32,
    parameter int REG_SZ     = 5,
    parameter int MEM_SZ     = 10,
    parameter int PROG_DEPTH = 256,
    parameter int MEM_DUMP   = 32
) (
    input  logic                                                i_clk,
    input  logic                                                i_reset,
    input  logic                                                i_cmd_valid,
    input  logic [1:0]                                          i_cmd,
    output logic                                                o_cmd_ready,
    input  logic                                                i_data_valid,
    input  logic [INST_SZ-1:0]                                  i_data,
    output logic                                                o_write,
    output logic [INST_SZ-1:0]                                  o_instruction,
    output logic                                                o_enable,
    output logic [((REG_SZ > MEM_SZ) ? REG_SZ : MEM_SZ)-1:0]   o_debug_addr,
    input  logic [INST_SZ-1:0]                                  i_pc,
    input  logic [INST_SZ-1:0]                                  i_reg,
    input  logic [INST_SZ-1:0]                                  i_mem,
    input  logic                                                i_halt,
    output logic                                                o_tx_valid,
    output logic [INST_SZ-1:0]                                  o_tx_data,
    input  logic                                                i_tx_ready,
    output logic                                                o_busy,
    output logic                                                o_halted,
    output logic                                                o_overflow,
    output logic [31:0]                                         o_cycles
);
    localparam int ADDR_W = (REG_SZ > MEM_SZ) ? REG_SZ : MEM_SZ;
    localparam int CNT_W  = $clog2(PROG_DEPTH + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_STEP     = 3'd3;
    localparam logic [2:0] S_DUMP_PC  = 3'd4;
    localparam logic [2:0] S_DUMP_REG = 3'd5;
    localparam logic [2:0] S_DUMP_MEM = 3'd6;

    localparam logic [1:0] CMD_LOAD = 2'd0;
    localparam logic [1:0] CMD_RUN  = 2'd1;
    localparam logic [1:0] CMD_STEP = 2'd2;
    localparam logic [1:0] CMD_DUMP = 2'd3;

    localparam logic [INST_SZ-1:0] HALT_WORD = INST_SZ'(32'h0000_003F);
    localparam logic [ADDR_W-1:0]  REG_LAST  = ADDR_W'((1 << REG_SZ) - 1);
    localparam logic [ADDR_W-1:0]  MEM_LAST  = ADDR_W'(MEM_DUMP - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] count;
    logic             primed;
    logic             accept;
    logic             full;
    logic             in_dump;

    assign accept        = i_cmd_valid && o_cmd_ready;
    assign full          = (count == CNT_W'(PROG_DEPTH));
    assign in_dump       = (state == S_DUMP_PC) || (state == S_DUMP_REG) || (state == S_DUMP_MEM);
    assign o_cmd_ready   = (state == S_IDLE);
    assign o_busy        = (state != S_IDLE);
    assign o_write       = (state == S_LOAD) && i_data_valid && !full;
    assign o_instruction = o_write ? i_data : '0;
    assign o_enable      = ((state == S_RUN) && !o_halted && !i_halt) ||
                           ((state == S_STEP) && !o_halted);
    // primed marks that debug data has had one cycle to follow the address
    assign o_tx_valid    = in_dump && primed;

    always_comb begin
        o_tx_data = '0;
        if (o_tx_valid) begin
            case (state)
                S_DUMP_PC:  o_tx_data = i_pc;
                S_DUMP_REG: o_tx_data = i_reg;
                S_DUMP_MEM: o_tx_data = i_mem;
                default:    o_tx_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_IDLE;
            count        <= '0;
            primed       <= 1'b0;
            o_debug_addr <= '0;
            o_halted     <= 1'b0;
            o_overflow   <= 1'b0;
            o_cycles     <= '0;
        end else begin
            if (o_enable && (o_cycles != '1))
                o_cycles <= o_cycles + 32'd1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (i_cmd)
                            CMD_LOAD: begin
                                state      <= S_LOAD;
                                count      <= '0;
                                o_halted   <= 1'b0;
                                o_overflow <= 1'b0;
                                o_cycles   <= '0;
                            end
                            CMD_RUN:  state <= S_RUN;
                            CMD_STEP: state <= S_STEP;
                            CMD_DUMP: begin
                                state        <= S_DUMP_PC;
                                o_debug_addr <= '0;
                                primed       <= 1'b0;
                            end
                            default:  state <= S_IDLE;
                        endcase
                    end else if (i_data_valid && full) begin
                        // a word arriving after a full program is dropped and flagged
                        o_overflow <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (o_write) begin
                        count <= count + CNT_W'(1);
                        if ((i_data == HALT_WORD) || (count + CNT_W'(1) == CNT_W'(PROG_DEPTH)))
                            state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (o_halted) begin
                        state <= S_IDLE;
                    end else if (i_halt) begin
                        o_halted <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (!o_halted && i_halt)
                        o_halted <= 1'b1;
                    state <= S_IDLE;
                end
                S_DUMP_PC: begin
                    if (!primed) begin
                        primed <= 1'b1;
                    end else if (i_tx_ready) begin
                        state        <= S_DUMP_REG;
                        o_debug_addr <= '0;
                        primed       <= 1'b0;
                    end
                end
                S_DUMP_REG: begin
                    if (!primed) begin
                        primed <= 1'b1;
                    end else if (i_tx_ready) begin
                        primed <= 1'b0;
                        if (o_debug_addr == REG_LAST) begin
                            state        <= S_DUMP_MEM;
                            o_debug_addr <= '0;
                        end else begin
                            o_debug_addr <= o_debug_addr + ADDR_W'(1);
                        end
                    end
                end
                S_DUMP_MEM: begin
                    if (!primed) begin
                        primed <= 1'b1;
                    end else if (i_tx_ready) begin
                        primed <= 1'b0;
                        if (o_debug_addr == MEM_LAST) begin
                            state        <= S_IDLE;
                            o_debug_addr <= '0;
                        end else begin
                            o_debug_addr <= o_debug_addr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb/tb_pipeline_debug_ctrl.sv - directed bench for pipeline_debug_ctrl
module tb_pipeline_debug_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        data_valid;
    logic [31:0] data;
    logic        wr;
    logic [31:0] instruction;
    logic        enable;
    logic [9:0]  dbg_addr;
    logic [31:0] pc_val;
    logic [31:0] reg_val;
    logic [31:0] mem_val;
    logic        halt;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        busy;
    logic        halted;
    logic        overflow;
    logic [31:0] cycles;

    int compared   = 0;
    int mismatched = 0;
    int beats;
    int got;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [9:0]  prev_addr;

    pipeline_debug_ctrl #(
        .INST_SZ(32), .REG_SZ(5), .MEM_SZ(10), .PROG_DEPTH(4), .MEM_DUMP(32)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
        .i_data_valid(data_valid), .i_data(data),
        .o_write(wr), .o_instruction(instruction), .o_enable(enable),
        .o_debug_addr(dbg_addr),
        .i_pc(pc_val), .i_reg(reg_val), .i_mem(mem_val), .i_halt(halt),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
        .o_busy(busy), .o_halted(halted), .o_overflow(overflow), .o_cycles(cycles)
    );

    always #5 clk = ~clk;

    // pipeline model: debug reads are registered, one cycle behind the address
    assign pc_val = 32'h0000_0400;
    always @(posedge clk) begin
        reg_val <= 32'(dbg_addr[4:0]);
        mem_val <= 32'hA000_0000 | 32'(dbg_addr);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_beat(input int b);
        if (b == 0)
            return 32'h0000_0400;
        else if (b <= 32)
            return 32'(b - 1);
        else
            return 32'hA000_0000 | 32'(b - 33);
    endfunction

    task automatic issue(input logic [1:0] c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd = c;
        #1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd = 2'd0; data_valid = 1'b0; data = '0;
        halt = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_write", 64'(wr), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_flags", 64'({halted, overflow}), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        rst = 1'b0;

        // LOAD three words, HALT word terminates
        issue(2'd0);
        #1;
        chk("load_busy", 64'(busy), 64'd1);
        chk("load_no_ready", 64'(cmd_ready), 64'd0);
        data_valid = 1'b1; data = 32'h2002_0002; #1;
        chk("load_w0_write", 64'(wr), 64'd1);
        chk("load_w0_instr", 64'(instruction), 64'h2002_0002);
        chk("load_w0_no_en", 64'(enable), 64'd0);
        @(negedge clk);
        data_valid = 1'b0; #1;
        chk("load_gap_write", 64'(wr), 64'd0);
        @(negedge clk);
        data_valid = 1'b1; data = 32'hAC02_0002; #1;
        chk("load_w1_write", 64'(wr), 64'd1);
        chk("load_w1_instr", 64'(instruction), 64'hAC02_0002);
        @(negedge clk);
        data = 32'h0000_003F; #1;
        chk("load_w2_write", 64'(wr), 64'd1);
        chk("load_w2_instr", 64'(instruction), 64'h0000_003F);
        @(negedge clk);
        data_valid = 1'b0; #1;
        chk("load_halt_idle", 64'(cmd_ready), 64'd1);
        chk("load_no_ovf", 64'(overflow), 64'd0);

        // LOAD five words with depth 4; a RUN offered mid-load is ignored
        issue(2'd0);
        for (int i = 0; i < 4; i++) begin
            data_valid = 1'b1; data = 32'h1111_0000 + 32'(i);
            if (i == 0) begin
                cmd_valid = 1'b1; cmd = 2'd1;
            end
            #1;
            chk("ovf_write", 64'(wr), 64'd1);
            chk("ovf_instr", 64'(instruction), 64'(32'h1111_0000 + 32'(i)));
            if (i == 0) chk("ovf_cmd_ignored", 64'(cmd_ready), 64'd0);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        data = 32'h1111_0004; #1;
        chk("ovf_5th_no_write", 64'(wr), 64'd0);
        chk("ovf_5th_instr", 64'(instruction), 64'd0);
        chk("ovf_5th_idle", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        data_valid = 1'b0; #1;
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_not_queued", 64'(busy), 64'd0);
        chk("ovf_no_enable", 64'(enable), 64'd0);

        // RUN for 12 cycles then halt
        issue(2'd1);
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("run_enable", 64'(enable), 64'd1);
            @(negedge clk);
        end
        halt = 1'b1; #1;
        chk("run_halt_drop", 64'(enable), 64'd0);
        @(negedge clk);
        halt = 1'b0; #1;
        chk("run_cycles", 64'(cycles), 64'd12);
        chk("run_halted", 64'(halted), 64'd1);
        chk("run_idle", 64'(busy), 64'd0);
        issue(2'd1);
        #1;
        chk("rerun_no_enable", 64'(enable), 64'd0);
        @(negedge clk);
        #1;
        chk("rerun_idle", 64'(busy), 64'd0);
        chk("rerun_cycles", 64'(cycles), 64'd12);

        // fresh load clears halted, then three steps
        issue(2'd0);
        data_valid = 1'b1; data = 32'h0000_003F;
        @(negedge clk);
        data_valid = 1'b0; #1;
        chk("reload_clr", 64'({halted, overflow}), 64'd0);
        chk("reload_cycles", 64'(cycles), 64'd0);
        for (int i = 0; i < 3; i++) begin
            issue(2'd2);
            #1;
            chk("step_enable", 64'(enable), 64'd1);
            @(negedge clk);
            #1;
            chk("step_drop", 64'(enable), 64'd0);
            chk("step_idle", 64'(busy), 64'd0);
        end
        chk("step_cycles", 64'(cycles), 64'd3);
        issue(2'd2);
        halt = 1'b1; #1;
        chk("step_halt_enable", 64'(enable), 64'd1);
        @(negedge clk);
        halt = 1'b0; #1;
        chk("step_halted", 64'(halted), 64'd1);
        chk("step_cycles4", 64'(cycles), 64'd4);

        // DUMP with tx_ready toggling
        issue(2'd3);
        beats = 0; prev_stall = 1'b0; prev_data = '0; prev_addr = '0;
        for (int c = 0; c < 500 && beats < 65; c++) begin
            if (c > 0) @(negedge clk);
            tx_ready = (c % 2 == 1);
            #1;
            chk("dump_no_enable", 64'(enable), 64'd0);
            if (prev_stall) begin
                chk("dump_hold_valid", 64'(tx_valid), 64'd1);
                chk("dump_hold_data", 64'(tx_data), 64'(prev_data));
                chk("dump_hold_addr", 64'(dbg_addr), 64'(prev_addr));
            end
            if (tx_valid && tx_ready) begin
                chk("dump_beat", 64'(tx_data), 64'(exp_beat(beats)));
                beats++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_addr  = dbg_addr;
        end
        chk("dump_beats", 64'(beats), 64'd65);
        @(negedge clk);
        tx_ready = 1'b0; #1;
        chk("dump_idle", 64'(busy), 64'd0);
        chk("dump_tx_off", 64'(tx_valid), 64'd0);

        // reset while beat 10 is pending
        issue(2'd3);
        beats = 0; got = 0;
        for (int c = 0; c < 300 && got == 0; c++) begin
            if (c > 0) @(negedge clk);
            tx_ready = (beats < 10);
            #1;
            if (tx_valid && !tx_ready) got = 1;
            else if (tx_valid && tx_ready) beats++;
        end
        chk("dump10_reached", 64'(got), 64'd1);
        chk("dump10_beats", 64'(beats), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("dump_rst_idle", 64'(cmd_ready), 64'd1);
        chk("dump_rst_tx", 64'(tx_valid), 64'd0);
        chk("dump_rst_cycles", 64'(cycles), 64'd0);
        chk("dump_rst_halted", 64'(halted), 64'd0);
        chk("dump_rst_addr", 64'(dbg_addr), 64'd0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
